// File: rtl/inport_ctrl_if.sv
// Channel-side and CPU-side signal bundle of the input-port controller.
// The controller uses the slave modport; the producer/control side uses master.
interface inport_ctrl_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS*WIDTH-1:0] ext_data;
   logic [CHANNELS-1:0]       ext_valid;
   logic [CHANNELS-1:0]       ext_ready;
   logic [SW-1:0]             sel;
   logic                      InPortout;
   logic [WIDTH-1:0]          bus_out;

   modport master (
      output ext_data, ext_valid, sel, InPortout,
      input  ext_ready, bus_out
   );

   modport slave (
      input  ext_data, ext_valid, sel, InPortout,
      output ext_ready, bus_out
   );
endinterface

// File: rtl/inport_ctrl.sv
// Input-port controller: per-channel FIFOs (or legacy single registers) feeding
// the datapath bus mux whenever the control unit strobes an In-instruction.
module inport_ctrl #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 4,
   parameter int LATCH    = 0
) (
   input  logic                clk,
   input  logic                clr,
   inport_ctrl_if.slave        bus,
   output logic [CHANNELS-1:0] avail,
   output logic [CHANNELS-1:0] underflow,
   input  logic                clr_flags,
   input  logic [CHANNELS-1:0] irq_en,
   output logic                irq
);
   localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [PW-1:0] PSTEP_C = PW'(1);

   logic [WIDTH-1:0]    mem_r       [CHANNELS][DEPTH];
   logic [PW-1:0]       wptr_r      [CHANNELS];
   logic [PW-1:0]       rptr_r      [CHANNELS];
   logic [CW-1:0]       count_r     [CHANNELS];
   logic [CW-1:0]       count_nxt_s [CHANNELS];
   logic [CHANNELS-1:0] underflow_r;
   logic [CHANNELS-1:0] push_s;
   logic [CHANNELS-1:0] pop_s;
   logic [CHANNELS-1:0] under_s;
   logic [CHANNELS-1:0] ready_s;
   logic [CHANNELS-1:0] avail_s;
   logic [WIDTH-1:0]    bus_out_s;
   logic                irq_r;

   // Per-channel request decode and first-word-fall-through read mux
   always_comb begin
      bus_out_s = {WIDTH{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         avail_s[i] = (count_r[i] != {CW{1'b0}});
         ready_s[i] = (LATCH != 0) ? 1'b1 : (count_r[i] != FULL_C);
         push_s[i]  = bus.ext_valid[i] & ready_s[i];
         // sel values outside 0..CHANNELS-1 match no channel and read as empty
         pop_s[i]   = bus.InPortout & (bus.sel == SW'(i)) & avail_s[i];
         under_s[i] = bus.InPortout & (bus.sel == SW'(i)) & ~avail_s[i];
         bus_out_s  = bus_out_s | (pop_s[i] ? mem_r[i][rptr_r[i]] : {WIDTH{1'b0}});
      end
   end

   // Occupancy update; in legacy mode the count only records "written since reset"
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         count_nxt_s[i] = count_r[i];
         if (LATCH != 0) begin
            count_nxt_s[i] = (push_s[i] | avail_s[i]) ? ONE_C : {CW{1'b0}};
         end else begin
            case ({push_s[i], pop_s[i]})
               2'b10:   count_nxt_s[i] = count_r[i] + ONE_C;
               2'b01:   count_nxt_s[i] = count_r[i] - ONE_C;
               default: count_nxt_s[i] = count_r[i];
            endcase
         end
      end
   end

   // Channel storage, pointers, occupancy and sticky underflow flags
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < CHANNELS; i++) begin
            wptr_r[i]  <= {PW{1'b0}};
            rptr_r[i]  <= {PW{1'b0}};
            count_r[i] <= {CW{1'b0}};
            for (int j = 0; j < DEPTH; j++) begin
               mem_r[i][j] <= {WIDTH{1'b0}};
            end
         end
         underflow_r <= {CHANNELS{1'b0}};
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (push_s[i]) begin
               mem_r[i][wptr_r[i]] <= bus.ext_data[i*WIDTH +: WIDTH];
               if (LATCH == 0) begin
                  wptr_r[i] <= wptr_r[i] + PSTEP_C;
               end
            end
            if (pop_s[i] && (LATCH == 0)) begin
               rptr_r[i] <= rptr_r[i] + PSTEP_C;
            end
            count_r[i] <= count_nxt_s[i];
         end
         // A same-edge underflow event wins over the clear
         underflow_r <= under_s | (underflow_r & ~{CHANNELS{clr_flags}});
      end
   end

   // Data-pending interrupt, one edge behind avail
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= |(avail_s & irq_en);
      end
   end

   assign bus.ext_ready = ready_s;
   assign bus.bus_out   = bus_out_s;
   assign avail         = avail_s;
   assign underflow     = underflow_r;
   assign irq           = irq_r;
endmodule

// File: tb/tb_inport_ctrl.sv
// Directed bench for inport_ctrl: a FIFO-mode vector table plus hand-written
// sequences for pointer wrap, mid-cycle reset and the legacy latch mode.
module tb_inport_ctrl;
   localparam int W = 32;
   localparam int C = 4;
   localparam int D = 4;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [1:0]  sel;
      logic        rd;
      logic        clrf;
      logic [3:0]  ien;
      logic [31:0] e_bus;
      logic [3:0]  e_rdy;
      logic [3:0]  e_av;
      logic [3:0]  e_uf;
      logic        e_irq;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         clr;
   logic         clr_flags;
   logic [C-1:0] irq_en;
   logic [C-1:0] avail_a, underflow_a, avail_b, underflow_b;
   logic         irq_a, irq_b;

   inport_ctrl_if #(.WIDTH(W), .CHANNELS(C)) ifa ();
   inport_ctrl_if #(.WIDTH(W), .CHANNELS(C)) ifb ();

   inport_ctrl #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .LATCH(0)) dut_a (
      .clk(clk), .clr(clr), .bus(ifa.slave), .avail(avail_a), .underflow(underflow_a),
      .clr_flags(clr_flags), .irq_en(irq_en), .irq(irq_a)
   );

   inport_ctrl #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .LATCH(1)) dut_b (
      .clk(clk), .clr(clr), .bus(ifb.slave), .avail(avail_b), .underflow(underflow_b),
      .clr_flags(clr_flags), .irq_en(irq_en), .irq(irq_b)
   );

   int   n_vec = 0;
   int   n_err = 0;
   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] valid, input logic [31:0] data, input logic [1:0] sel,
                      input logic rd, input logic clrf, input logic [3:0] ien,
                      input logic [31:0] e_bus, input logic [3:0] e_rdy, input logic [3:0] e_av,
                      input logic [3:0] e_uf, input logic e_irq);
      vq.push_back('{valid, data, sel, rd, clrf, ien, e_bus, e_rdy, e_av, e_uf, e_irq});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [3:0] valid, input logic [31:0] data,
                          input logic [1:0] sel, input logic rd);
      ifa.ext_valid = valid;
      ifa.ext_data  = {C{data}};
      ifa.sel       = sel;
      ifa.InPortout = rd;
   endtask

   task automatic drive_b(input logic [3:0] valid, input logic [31:0] data,
                          input logic [1:0] sel, input logic rd);
      ifb.ext_valid = valid;
      ifb.ext_data  = {C{data}};
      ifb.sel       = sel;
      ifb.InPortout = rd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clr = 1'b0;
      clr_flags = 1'b0;
      irq_en = 4'h0;
      drive_a(4'h0, 32'h0, 2'd0, 1'b1);
      drive_b(4'h0, 32'h0, 2'd0, 1'b0);
      step();
      step();
      check("rst bus_out", ifa.bus_out, 32'h0);
      check("rst ready", {28'h0, ifa.ext_ready}, 32'hF);
      check("rst avail", {28'h0, avail_a}, 32'h0);
      check("rst irq", {31'h0, irq_a}, 32'h0);
      clr = 1'b1;
      drive_a(4'h0, 32'h0, 2'd0, 1'b0);
      step();

      // valid data sel rd clrf ien | bus rdy av uf irq
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h1, 32'd7,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b1, 1'b0, 4'hF, 32'd7,  4'hF, 4'h1, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b1);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h4, 32'd1,  2'd0, 1'b0, 1'b0, 4'h1, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h4, 32'd2,  2'd0, 1'b0, 1'b0, 4'h1, 32'd0,  4'hF, 4'h4, 4'h0, 1'b0);
      add(4'h4, 32'd3,  2'd0, 1'b0, 1'b0, 4'h1, 32'd0,  4'hF, 4'h4, 4'h0, 1'b0);
      add(4'h4, 32'd4,  2'd0, 1'b0, 1'b0, 4'h1, 32'd0,  4'hF, 4'h4, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd2, 1'b1, 1'b0, 4'h1, 32'd1,  4'hB, 4'h4, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd2, 1'b1, 1'b0, 4'h1, 32'd2,  4'hF, 4'h4, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd2, 1'b1, 1'b0, 4'h1, 32'd3,  4'hF, 4'h4, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd2, 1'b1, 1'b0, 4'h1, 32'd4,  4'hF, 4'h4, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd1, 1'b1, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h2, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b1, 4'hF, 32'd0,  4'hF, 4'h0, 4'h2, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd1, 1'b1, 1'b1, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h2, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b1, 4'hF, 32'd0,  4'hF, 4'h0, 4'h2, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'hF, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h2, 32'd9,  2'd1, 1'b1, 1'b0, 4'h0, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd1, 1'b1, 1'b1, 4'h0, 32'd9,  4'hF, 4'h2, 4'h2, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'h0, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h1, 32'd20, 2'd0, 1'b0, 1'b0, 4'h0, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);
      add(4'h1, 32'd21, 2'd0, 1'b0, 1'b0, 4'h0, 32'd0,  4'hF, 4'h1, 4'h0, 1'b0);
      add(4'h1, 32'd22, 2'd0, 1'b0, 1'b0, 4'h0, 32'd0,  4'hF, 4'h1, 4'h0, 1'b0);
      add(4'h1, 32'd23, 2'd0, 1'b0, 1'b0, 4'h0, 32'd0,  4'hF, 4'h1, 4'h0, 1'b0);
      add(4'h1, 32'd24, 2'd0, 1'b1, 1'b0, 4'h0, 32'd20, 4'hE, 4'h1, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b1, 1'b0, 4'h0, 32'd21, 4'hF, 4'h1, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b1, 1'b0, 4'h0, 32'd22, 4'hF, 4'h1, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b1, 1'b0, 4'h0, 32'd23, 4'hF, 4'h1, 4'h0, 1'b0);
      add(4'h0, 32'd0,  2'd0, 1'b0, 1'b0, 4'h0, 32'd0,  4'hF, 4'h0, 4'h0, 1'b0);

      for (int i = 0; i < vq.size(); i++) begin
         drive_a(vq[i].valid, vq[i].data, vq[i].sel, vq[i].rd);
         clr_flags = vq[i].clrf;
         irq_en    = vq[i].ien;
         @(negedge clk);
         check($sformatf("v%0d bus_out", i),   ifa.bus_out, vq[i].e_bus);
         check($sformatf("v%0d ext_ready", i), {28'h0, ifa.ext_ready}, {28'h0, vq[i].e_rdy});
         check($sformatf("v%0d avail", i),     {28'h0, avail_a}, {28'h0, vq[i].e_av});
         check($sformatf("v%0d underflow", i), {28'h0, underflow_a}, {28'h0, vq[i].e_uf});
         check($sformatf("v%0d irq", i),       {31'h0, irq_a}, {31'h0, vq[i].e_irq});
         step();
      end
      clr_flags = 1'b0;
      irq_en    = 4'h0;

      // ch3 held at two words while pushing and popping together across the wrap
      drive_a(4'h8, 32'd10, 2'd3, 1'b0);
      step();
      drive_a(4'h8, 32'd11, 2'd3, 1'b0);
      step();
      for (int k = 0; k < 6; k++) begin
         drive_a(4'h8, 32'd12 + 32'(k), 2'd3, 1'b1);
         @(negedge clk);
         check($sformatf("wrap%0d bus_out", k), ifa.bus_out, 32'd10 + 32'(k));
         check($sformatf("wrap%0d ready", k), {28'h0, ifa.ext_ready}, 32'hF);
         check($sformatf("wrap%0d avail", k), {28'h0, avail_a}, 32'h8);
         step();
      end
      for (int k = 0; k < 2; k++) begin
         drive_a(4'h0, 32'd0, 2'd3, 1'b1);
         @(negedge clk);
         check($sformatf("drain%0d bus_out", k), ifa.bus_out, 32'd16 + 32'(k));
         check($sformatf("drain%0d avail", k), {28'h0, avail_a}, 32'h8);
         step();
      end
      drive_a(4'h0, 32'd0, 2'd3, 1'b0);
      @(negedge clk);
      check("drain empty avail", {28'h0, avail_a}, 32'h0);
      check("drain underflow", {28'h0, underflow_a}, 32'h0);
      step();

      // Asynchronous reset between edges with three words buffered on ch0
      for (int k = 0; k < 3; k++) begin
         drive_a(4'h1, 32'hA0 + 32'(k), 2'd0, 1'b0);
         step();
      end
      drive_a(4'h0, 32'd0, 2'd0, 1'b1);
      #1;
      check("pre-reset head", ifa.bus_out, 32'hA0);
      #1;
      clr = 1'b0;
      #1;
      check("async rst avail", {28'h0, avail_a}, 32'h0);
      check("async rst ready", {28'h0, ifa.ext_ready}, 32'hF);
      check("async rst bus_out", ifa.bus_out, 32'h0);
      step();
      clr = 1'b1;
      drive_a(4'h1, 32'h55, 2'd0, 1'b0);
      step();
      drive_a(4'h0, 32'd0, 2'd0, 1'b1);
      @(negedge clk);
      check("post-rst first word", ifa.bus_out, 32'h55);
      step();
      drive_a(4'h0, 32'd0, 2'd0, 1'b0);
      @(negedge clk);
      check("post-rst empty", {28'h0, avail_a}, 32'h0);
      check("post-rst underflow", {28'h0, underflow_a}, 32'h0);
      step();

      // Legacy latch mode: overwrite, non-consuming reads, never-written channel
      check("latch ready", {28'h0, ifb.ext_ready}, 32'hF);
      check("latch avail rst", {28'h0, avail_b}, 32'h0);
      drive_b(4'h2, 32'd5, 2'd1, 1'b0);
      step();
      drive_b(4'h2, 32'd9, 2'd1, 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin
         drive_b(4'h0, 32'd0, 2'd1, 1'b1);
         @(negedge clk);
         check($sformatf("latch rd%0d bus_out", k), ifb.bus_out, 32'd9);
         check($sformatf("latch rd%0d avail", k), {28'h0, avail_b}, 32'h2);
         check($sformatf("latch rd%0d ready", k), {28'h0, ifb.ext_ready}, 32'hF);
         step();
      end
      drive_b(4'h0, 32'd0, 2'd2, 1'b1);
      @(negedge clk);
      check("latch unwritten bus_out", ifb.bus_out, 32'h0);
      check("latch no underflow yet", {28'h0, underflow_b}, 32'h0);
      step();
      drive_b(4'h0, 32'd0, 2'd0, 1'b0);
      @(negedge clk);
      check("latch underflow ch2", {28'h0, underflow_b}, 32'h4);
      check("latch avail kept", {28'h0, avail_b}, 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
